// File: rtl/phase_pkg.sv
// phase_pkg -- shared types and constants for the phase/frequency datapath.
//   q3_13_t        : 16-bit signed Q3.13 phase (radians)
//   PHASE_PI       : +pi in Q3.13 (25736)
//   PHASE_HALF_PI  : +pi/2 in Q3.13 (12868)
//   PHASE_TWO_PI   : 2*pi in Q3.13, 17 bits wide (51472 does not fit in 16 signed bits)
//   state_t        : EMPTY (no previous sample held) / RUN
package phase_pkg;

  typedef logic signed [15:0] q3_13_t;

  localparam q3_13_t      PHASE_PI      = 16'h6488;
  localparam q3_13_t      PHASE_HALF_PI = 16'h3244;
  localparam logic [16:0] PHASE_TWO_PI  = 17'd51472;

  typedef enum logic {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/phase_wrap.sv
// phase_wrap -- folds a raw 17-bit phase difference back into (-pi, pi].
// Purely combinational.
//   d_raw : signed difference of two Q3.13 phases, range [-2*pi, 2*pi]
//   d     : wrapped difference, Q3.13; exact +pi is kept, exact -pi becomes +pi
module phase_wrap
  import phase_pkg::*;
(
  input  logic signed [16:0] d_raw,
  output q3_13_t             d
);

  logic signed [16:0] pi_ext;
  logic signed [16:0] two_pi;
  logic signed [16:0] d_wide;

  assign pi_ext = {PHASE_PI[15], PHASE_PI};
  assign two_pi = $signed(PHASE_TWO_PI);

  always_comb begin
    // NOTE: default assignment first, so every path drives d_wide and no latch is inferred.
    d_wide = d_raw;
    if (d_raw > pi_ext) begin
      d_wide = d_raw - two_pi;
    end else if (d_raw <= -pi_ext) begin
      d_wide = d_raw + two_pi;
    end
  end

  // After folding the value lies in (-pi, pi], so the top bit is pure sign.
  assign d = q3_13_t'(d_wide);

endmodule

// File: rtl/phase_diff_avg.sv
// phase_diff_avg -- instantaneous-frequency estimator behind the atan2 stage.
// Takes the wrapped difference between consecutive valid phase samples and
// emits the mean of every 2^LOG2N differences.
//   clk          : clock, rising edge
//   rst          : asynchronous, active-high reset
//   sink_phase   : Q3.13 phase sample
//   sink_valid   : sink_phase valid this cycle
//   flush        : synchronous restart, drops history and the partial block
//   source       : averaged difference, Q3.13, holds between strobes
//   source_valid : one-cycle strobe when source updates
// Pipeline: A (raw difference) -> B (wrapped difference) -> C (accumulate/emit),
// so the sample completing a block shows on source two edges after it is taken.
module phase_diff_avg
  import phase_pkg::*;
#(
  parameter int LOG2N = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  q3_13_t sink_phase,
  input  logic   sink_valid,
  input  logic   flush,
  output q3_13_t source,
  output logic   source_valid
);

  localparam int ACC_W = 16 + LOG2N;

  state_t state;
  state_t state_next;
  logic   accept_first;
  logic   accept_diff;

  q3_13_t             prev;
  logic signed [16:0] d_raw;
  logic               d_valid;
  q3_13_t             d_wrap;
  q3_13_t             d_reg;
  logic               d_reg_valid;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic [LOG2N-1:0]        cnt;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else if (sink_valid) begin
      state_next = RUN;
    end
  end

  // ---------------- FSM: outputs ----------------
  // flush beats sink_valid, so a sample arriving with flush is dropped.
  always_comb begin
    accept_first = 1'b0;
    accept_diff  = 1'b0;
    if (sink_valid && !flush) begin
      accept_first = (state == EMPTY);
      accept_diff  = (state == RUN);
    end
  end

  // ---------------- Stage A: raw difference ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= '0;
      d_raw   <= '0;
      d_valid <= 1'b0;
    end else begin
      d_valid <= accept_diff;
      if (accept_diff) begin
        d_raw <= {sink_phase[15], sink_phase} - {prev[15], prev};
      end
      if (accept_first || accept_diff) begin
        prev <= sink_phase;
      end
    end
  end

  // ---------------- Stage B: wrap into (-pi, pi] ----------------
  phase_wrap u_wrap (
    .d_raw (d_raw),
    .d     (d_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_reg       <= '0;
      d_reg_valid <= 1'b0;
    end else begin
      d_reg_valid <= d_valid && !flush;
      if (d_valid) begin
        d_reg <= d_wrap;
      end
    end
  end

  // ---------------- Stage C: accumulate and emit ----------------
  // LOG2N guard bits: 2^LOG2N values of |d| <= pi can never overflow acc.
  assign acc_sum = acc + $signed({{LOG2N{d_reg[15]}}, d_reg});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      source       <= '0;
      source_valid <= 1'b0;
    end else begin
      source_valid <= 1'b0;
      if (flush) begin
        acc <= '0;
        cnt <= '0;
      end else if (d_reg_valid) begin
        if (cnt == '1) begin
          // Arithmetic shift: the mean rounds toward -inf; it always fits 16 bits.
          source       <= q3_13_t'(acc_sum >>> LOG2N);
          source_valid <= 1'b1;
          acc          <= '0;
          cnt          <= '0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + LOG2N'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_diff_avg.sv
// tb_phase_diff_avg -- directed bench for phase_diff_avg.
// Two instances: u1 with LOG2N=1 and u2 with LOG2N=2, sharing clk and rst.
// Expected outputs (value + due cycle) are queued when the block-completing
// sample is driven; per-instance monitors pop and compare on each strobe.
module tb_phase_diff_avg;
  import phase_pkg::*;

  typedef struct {
    q3_13_t val;
    int     due;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst;
  q3_13_t p1, p2;
  logic   v1, v2, f1, f2;
  q3_13_t s1, s2;
  logic   sv1, sv2;

  logic signed [16:0] w_raw;
  q3_13_t             w_d;

  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  phase_diff_avg #(.LOG2N(1)) u1 (
    .clk          (clk),
    .rst          (rst),
    .sink_phase   (p1),
    .sink_valid   (v1),
    .flush        (f1),
    .source       (s1),
    .source_valid (sv1)
  );

  phase_diff_avg #(.LOG2N(2)) u2 (
    .clk          (clk),
    .rst          (rst),
    .sink_phase   (p2),
    .sink_valid   (v2),
    .flush        (f2),
    .source       (s2),
    .source_valid (sv2)
  );

  phase_wrap u_ref (
    .d_raw (w_raw),
    .d     (w_d)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One input cycle on instance `which`, applied at the falling edge.
  task automatic drv(input int which, input logic [15:0] p, input logic v, input logic fl);
    @(negedge clk);
    if (which == 1) begin
      p1 = p; v1 = v; f1 = fl;
    end else begin
      p2 = p; v2 = v; f2 = fl;
    end
  endtask

  task automatic sample(input int which, input logic [15:0] p);
    drv(which, p, 1'b1, 1'b0);
  endtask

  task automatic idle(input int which, input int n);
    for (int i = 0; i < n; i++) drv(which, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic do_flush(input int which);
    drv(which, 16'h0000, 1'b0, 1'b1);
  endtask

  // Called right after the block-completing sample is driven: the strobe is
  // due three falling edges later (edges k, k+1, k+2 in between).
  task automatic expect_out(input int which, input q3_13_t val);
    exp_t e;
    e.val = val;
    e.due = cyc + 3;
    if (which == 1) q1.push_back(e);
    else            q2.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sv1) begin
      check("u1_strobe_expected", 16'(q1.size() != 0), 16'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("u1_source", s1, e1.val);
        check("u1_latency", 16'(cyc), 16'(e1.due));
      end
    end else if (q1.size() != 0 && q1[0].due <= cyc) begin
      check("u1_strobe_on_time", 16'(sv1), 16'd1);
      void'(q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (sv2) begin
      check("u2_strobe_expected", 16'(q2.size() != 0), 16'd1);
      if (q2.size() != 0) begin
        e2 = q2.pop_front();
        check("u2_source", s2, e2.val);
        check("u2_latency", 16'(cyc), 16'(e2.due));
      end
    end else if (q2.size() != 0 && q2[0].due <= cyc) begin
      check("u2_strobe_on_time", 16'(sv2), 16'd1);
      void'(q2.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    p1 = '0; v1 = 1'b0; f1 = 1'b0;
    p2 = '0; v2 = 1'b0; f2 = 1'b0;
    w_raw = '0;
    #12;
    check("reset_u1_source", s1, 16'h0000);
    check("reset_u1_valid", 16'(sv1), 16'd0);
    check("reset_u2_source", s2, 16'h0000);
    check("reset_u2_valid", 16'(sv2), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Wrap rule at and around the +/-pi boundaries.
    w_raw = 17'sd25736;  #1 check("wrap_plus_pi", w_d, 16'h6488);
    w_raw = -17'sd25736; #1 check("wrap_minus_pi", w_d, 16'h6488);
    w_raw = 17'sd25737;  #1 check("wrap_above_pi", w_d, 16'h9B79);
    w_raw = -17'sd25737; #1 check("wrap_below_minus_pi", w_d, 16'h6487);
    w_raw = {PHASE_HALF_PI[15], PHASE_HALF_PI};
    #1 check("wrap_half_pi", w_d, PHASE_HALF_PI);
    w_raw = -17'sd51472; #1 check("wrap_minus_two_pi", w_d, 16'h0000);

    // LOG2N=2 ramp: four differences of 0x0400.
    sample(2, 16'h0000);
    sample(2, 16'h0400);
    sample(2, 16'h0800);
    sample(2, 16'h0C00);
    sample(2, 16'h1000);
    expect_out(2, 16'h0400);
    idle(2, 6);
    check("u2_source_holds", s2, 16'h0400);

    // LOG2N=1 across +pi: both differences are 1160.
    sample(1, 16'h6000);
    sample(1, 16'h6488);
    sample(1, 16'hA000);
    expect_out(1, 16'h0488);
    idle(1, 5);

    // LOG2N=1 exact +pi and -pi differences both give +pi.
    do_flush(1);
    sample(1, 16'h0000);
    sample(1, 16'h6488);
    sample(1, 16'h0000);
    expect_out(1, 16'h6488);
    idle(1, 5);
    check("u1_source_holds", s1, 16'h6488);

    // LOG2N=1 negative mean: (-1 + -2) >>> 1 = -2 (toward -inf).
    do_flush(1);
    sample(1, 16'h0000);
    sample(1, 16'hFFFF);
    sample(1, 16'hFFFD);
    expect_out(1, 16'hFFFE);
    idle(1, 5);

    // LOG2N=1 flush together with a sample: the sample is dropped.
    do_flush(1);
    drv(1, 16'h1000, 1'b1, 1'b1);
    sample(1, 16'h0100);
    sample(1, 16'h0200);
    sample(1, 16'h0300);
    expect_out(1, 16'h0100);
    idle(1, 5);
    do_flush(1);
    idle(1, 2);
    check("u1_flush_keeps_source", s1, 16'h0100);

    // LOG2N=2 descending step, first without gaps, then with random gaps.
    do_flush(2);
    for (int n = 0; n < 5; n++) sample(2, 16'(-(n * 16'h0200)));
    expect_out(2, 16'hFE00);
    idle(2, 5);
    do_flush(2);
    for (int n = 0; n < 5; n++) begin
      sample(2, 16'(-(n * 16'h0200)));
      if (n == 4) expect_out(2, 16'hFE00);
      idle(2, int'($urandom_range(0, 3)));
    end
    idle(2, 5);

    // LOG2N=2 flush after two differences, right as the second is in flight.
    do_flush(2);
    sample(2, 16'h0000);
    sample(2, 16'h0400);
    sample(2, 16'h0800);
    do_flush(2);
    for (int n = 0; n < 5; n++) sample(2, 16'(16'h1000 + n * 16'h0100));
    expect_out(2, 16'h0100);
    idle(2, 5);

    // Asynchronous reset mid-block, between clock edges.
    do_flush(2);
    sample(2, 16'h0000);
    sample(2, 16'h0100);
    sample(2, 16'h0200);
    idle(2, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_u2_source", s2, 16'h0000);
    check("async_rst_u2_valid", 16'(sv2), 16'd0);
    check("async_rst_u1_source", s1, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) sample(2, 16'(16'h0300 + n * 16'h0080));
    expect_out(2, 16'h0080);
    idle(2, 6);

    check("u1_queue_drained", 16'(q1.size()), 16'd0);
    check("u2_queue_drained", 16'(q2.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
